contador_monitor: RTL and testbench

Sequence monitor for the modulo-10 count bus produced by the team's counters. It samples a 4-bit count value on every enabled clock edge and checks that the bus steps 0,1,…,9,0,… with no skips, repeats or out-of-range codes. It reports lock status, pulses an error flag on every violation, and keeps error and wrap statistics. It sits on the consumer end of the count interface and serves both in-system health checks and bench scoreboarding.

---
 rtl/contador_pkg.sv | 20 ++
 rtl/sat_counter.sv | 28 ++
 rtl/contador_monitor.sv | 132 +++++++++++++
 tb/tb_contador_monitor.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// contador_pkg
// Definitions shared by the modulo-N counters and the sequence monitor.
//   state_t    : monitor tracking state (IDLE, HUNT, LOCKED)
//   next_count : successor of a count value on a 0..max wrapping bus
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no valid previous sample
    HUNT   = 2'd1,  // previous sample valid, counting correct steps
    LOCKED = 2'd2   // sequence confirmed
  } state_t;

  // Kept at 32 bits so callers of any bus width can share one definition.
  // They cast the result back to their own width.
  function automatic logic [31:0] next_count(input logic [31:0] prev,
                                             input logic [31:0] max_v);
    return (prev == max_v) ? 32'd0 : prev + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter: counts inc pulses and holds at all-ones.
//   clk   : clock, rising edge
//   srst  : synchronous active-high clear
//   inc   : increment request for this edge
//   count : registered count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/contador_monitor.sv
// contador_monitor
// Checks that a count bus steps 0,1,...,MAX,0,... on every enabled edge.
//   c       : clock, rising edge
//   reset   : synchronous active-high reset
//   en      : sample i at this edge
//   i       : observed count value
//   locked  : sequence tracked for LOCK_N consecutive correct steps
//   err     : one-cycle pulse per violation seen while locked
//   err_cnt : saturating violation count
//   wraps   : MAX->0 steps seen while locked (wraps around)
//   last    : most recent in-range sample
module contador_monitor
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MAX    = 9,
  parameter int LOCK_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             c,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wraps,
  output logic [WIDTH-1:0] last
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  // good never exceeds LOCK_N, so this width always holds it.
  localparam int GOOD_W = $clog2(LOCK_N + 1);

  state_t            state_reg;
  logic [WIDTH-1:0]  prev_reg;
  logic [GOOD_W-1:0] good_reg;
  logic [CNT_W-1:0]  wraps_reg;
  logic              err_reg;
  logic              locked_reg;

  logic [WIDTH-1:0]  exp_next;
  logic [31:0]       good_inc;
  logic              in_range;
  logic              match;
  logic              violation;

  assign exp_next  = WIDTH'(next_count(32'(prev_reg), 32'(MAX)));
  assign good_inc  = 32'(good_reg) + 32'd1;
  assign in_range  = (i <= MAX_W);
  assign match     = (i == exp_next);
  assign violation = en && (state_reg == LOCKED) && !match;

  always_ff @(posedge c) begin
    if (reset) begin
      state_reg  <= IDLE;
      prev_reg   <= '0;
      good_reg   <= '0;
      wraps_reg  <= '0;
      err_reg    <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (en) begin
        case (state_reg)
          IDLE: begin
            // Out-of-range codes are ignored until a usable sample arrives.
            if (in_range) begin
              prev_reg  <= i;
              good_reg  <= '0;
              state_reg <= HUNT;
            end
          end
          HUNT: begin
            if (!in_range) begin
              state_reg <= IDLE;
            end else if (match) begin
              prev_reg <= i;
              good_reg <= GOOD_W'(good_inc);
              if (good_inc == 32'(LOCK_N)) begin
                state_reg  <= LOCKED;
                locked_reg <= 1'b1;
              end
            end else begin
              // Resynchronise on the new value without flagging an error.
              prev_reg <= i;
              good_reg <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              prev_reg <= i;
              // A match after MAX can only be 0, so this is the wrap step.
              if (prev_reg == MAX_W) begin
                wraps_reg <= wraps_reg + CNT_W'(1);
              end
            end else begin
              err_reg    <= 1'b1;
              locked_reg <= 1'b0;
              good_reg   <= '0;
              if (in_range) begin
                prev_reg  <= i;
                state_reg <= HUNT;
              end else begin
                state_reg <= IDLE;
              end
            end
          end
          default: begin
            state_reg  <= IDLE;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk   (c),
    .srst  (reset),
    .inc   (violation),
    .count (err_cnt)
  );

  assign locked = locked_reg;
  assign err    = err_reg;
  assign wraps  = wraps_reg;
  assign last   = prev_reg;

endmodule

// File: tb/tb_contador_monitor.sv
// tb_contador_monitor
// Directed bench for contador_monitor (WIDTH=4, MAX=9, LOCK_N=2, CNT_W=2).
module tb_contador_monitor;

  logic       c = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] i = 4'd0;
  logic       locked;
  logic       err;
  logic [1:0] err_cnt;
  logic [1:0] wraps;
  logic [3:0] last;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  contador_monitor #(
    .WIDTH (4),
    .MAX   (9),
    .LOCK_N(2),
    .CNT_W (2)
  ) dut (
    .c      (c),
    .reset  (reset),
    .en     (en),
    .i      (i),
    .locked (locked),
    .err    (err),
    .err_cnt(err_cnt),
    .wraps  (wraps),
    .last   (last)
  );

  always #5 c = ~c;

  // Apply one sample, clock it in, and settle 1 time unit past the edge.
  task automatic step(input logic e, input logic [3:0] v);
    en = e;
    i  = v;
    @(posedge c);
    #1;
    if (err === 1'b1) err_pulses++;
    $display("step en=%0d i=%0d -> locked=%0d err=%0d err_cnt=%0d wraps=%0d last=%0d",
             e, v, locked, err, err_cnt, wraps, last);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input int lk, input int er,
                         input int ec, input int wr, input int ls);
    chk({tag, ".locked"},  32'(locked),  32'(lk));
    chk({tag, ".err"},     32'(err),     32'(er));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
    chk({tag, ".wraps"},   32'(wraps),   32'(wr));
    chk({tag, ".last"},    32'(last),    32'(ls));
  endtask

  initial begin
    // Reset for two edges with random data, then hold with en=0.
    reset = 1'b1;
    step(1'b1, 4'($urandom_range(15)));
    step(1'b1, 4'($urandom_range(15)));
    reset = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'($urandom_range(15)));
    chk_all("hold", 0, 0, 0, 0, 0);

    // Lock and wrap: 7,8,9,0,1.
    step(1'b1, 4'd7); chk_all("lk7", 0, 0, 0, 0, 7);
    step(1'b1, 4'd8); chk_all("lk8", 0, 0, 0, 0, 8);
    step(1'b1, 4'd9); chk_all("lk9", 1, 0, 0, 0, 9);
    step(1'b1, 4'd0); chk_all("lk0", 1, 0, 0, 1, 0);
    step(1'b1, 4'd1); chk_all("lk1", 1, 0, 0, 1, 1);

    // Skip while locked: 2 then 4, relock on 5,6.
    step(1'b1, 4'd2); chk_all("sk2", 1, 0, 0, 1, 2);
    step(1'b1, 4'd4); chk_all("sk4", 0, 1, 1, 1, 4);
    step(1'b1, 4'd5); chk_all("sk5", 0, 0, 1, 1, 5);
    step(1'b1, 4'd6); chk_all("sk6", 1, 0, 1, 1, 6);

    // Out-of-range while locked: 12 drops to IDLE, then 3,4,5 relock.
    step(1'b1, 4'd12); chk_all("oor12", 0, 1, 2, 1, 6);
    step(1'b1, 4'd3);  chk_all("oor3", 0, 0, 2, 1, 3);
    step(1'b1, 4'd4);  chk_all("oor4", 0, 0, 2, 1, 4);
    step(1'b1, 4'd5);  chk_all("oor5", 1, 0, 2, 1, 5);

    // Gaps inside a correct sequence keep lock and raise nothing.
    step(1'b0, 4'd9);  chk_all("gap_a", 1, 0, 2, 1, 5);
    step(1'b0, 4'd13); chk_all("gap_b", 1, 0, 2, 1, 5);
    step(1'b1, 4'd6);  chk_all("gap6", 1, 0, 2, 1, 6);
    step(1'b0, 4'd0);  chk_all("gap_c", 1, 0, 2, 1, 6);
    step(1'b1, 4'd7);  chk_all("gap7", 1, 0, 2, 1, 7);

    // Five violations with relock between them; err_cnt saturates at 3.
    err_pulses = 0;
    step(1'b1, 4'd0);  chk_all("v1", 0, 1, 3, 1, 0);
    step(1'b1, 4'd1);  chk_all("v1r1", 0, 0, 3, 1, 1);
    step(1'b1, 4'd2);  chk_all("v1r2", 1, 0, 3, 1, 2);
    step(1'b1, 4'd5);  chk_all("v2", 0, 1, 3, 1, 5);
    step(1'b1, 4'd6);  chk_all("v2r1", 0, 0, 3, 1, 6);
    step(1'b1, 4'd7);  chk_all("v2r2", 1, 0, 3, 1, 7);
    step(1'b1, 4'd15); chk_all("v3", 0, 1, 3, 1, 7);
    step(1'b1, 4'd1);  chk_all("v3r1", 0, 0, 3, 1, 1);
    step(1'b1, 4'd2);  chk_all("v3r2", 0, 0, 3, 1, 2);
    step(1'b1, 4'd3);  chk_all("v3r3", 1, 0, 3, 1, 3);
    step(1'b1, 4'd3);  chk_all("v4", 0, 1, 3, 1, 3);
    step(1'b1, 4'd4);  chk_all("v4r1", 0, 0, 3, 1, 4);
    step(1'b1, 4'd5);  chk_all("v4r2", 1, 0, 3, 1, 5);
    step(1'b1, 4'd9);  chk_all("v5", 0, 1, 3, 1, 9);
    step(1'b1, 4'd0);  chk_all("v5r1", 0, 0, 3, 1, 0);
    step(1'b1, 4'd1);  chk_all("v5r2", 1, 0, 3, 1, 1);
    chk("err_pulses", 32'(err_pulses), 32'd5);

    // Run to the next wrap so wraps reaches 2.
    for (int v = 2; v <= 9; v++) begin
      step(1'b1, 4'(v));
      chk("run.locked", 32'(locked), 32'd1);
    end
    step(1'b1, 4'd0); chk_all("wrap2", 1, 0, 3, 2, 0);

    // Reset mid-lock with a correct sample present: everything clears.
    reset = 1'b1;
    step(1'b1, 4'd1);
    reset = 1'b0;
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    step(1'b0, 4'd1); chk_all("rst_hold", 0, 0, 0, 0, 0);
    // The sample at the reset edge was discarded: 2,3 only reach HUNT.
    step(1'b1, 4'd2); chk_all("post2", 0, 0, 0, 0, 2);
    step(1'b1, 4'd3); chk_all("post3", 0, 0, 0, 0, 3);
    step(1'b1, 4'd4); chk_all("post4", 1, 0, 0, 0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
